biriscv_divider: RTL and testbench

- Multi-cycle integer divide unit for the RV32M DIV, DIVU, REM and REMU instructions.
- Sits beside the combinational single-cycle ALU in the execute stage. The issue stage hands it operands, and the result returns through a one-cycle writeback pulse.
- Radix-2 restoring algorithm on operand magnitudes, with sign fix-up at the end.
- Divide-by-zero takes a fast path.

---
 rtl/biriscv_divider_pkg.sv | 23 ++
 rtl/biriscv_divider.sv | 111 +++++++++++
 tb/tb_biriscv_divider.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/biriscv_divider_pkg.sv
// Shared types and helpers for the biriscv multi-cycle divide unit.
package biriscv_divider_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } div_state_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  // Two's-complement magnitude; unsigned ops pass the operand through untouched.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/biriscv_divider.sv
// RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring divide on magnitudes,
// 32 iteration cycles, sign fix-up at writeback, fast path for divide-by-zero.
module biriscv_divider
  import biriscv_divider_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            opcode_valid_i,
  input  logic            inst_div_i,
  input  logic            inst_divu_i,
  input  logic            inst_rem_i,
  input  logic            inst_remu_i,
  input  logic [XLEN-1:0] operand_ra_i,
  input  logic [XLEN-1:0] operand_rb_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            writeback_valid_o,
  output logic [XLEN-1:0] writeback_value_o
);

  div_state_e       state_q, state_d;
  logic [XLEN:0]    remainder_q;
  logic [XLEN-1:0]  quotient_q;
  logic [XLEN-1:0]  divisor_q;
  logic [CNT_W-1:0] count_q;
  logic             is_rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic [3:0]       inst_bits;
  logic             accept;
  logic             div_by_zero;
  logic             op_signed;
  logic             op_rem;
  logic [XLEN+1:0]  diff;
  logic             fits;
  logic [XLEN-1:0]  result;

  assign inst_bits   = {inst_remu_i, inst_rem_i, inst_divu_i, inst_div_i};
  assign accept      = opcode_valid_i && is_onehot4(inst_bits) &&
                       (state_q == ST_IDLE) && !flush_i;
  assign div_by_zero = (operand_rb_i == '0);
  assign op_signed   = inst_div_i | inst_rem_i;
  assign op_rem      = inst_rem_i | inst_remu_i;

  // Trial subtract on the shifted {remainder, quotient} pair; the extra top bit is the borrow.
  assign diff = {remainder_q, quotient_q[XLEN-1]} - {2'b00, divisor_q};
  assign fits = ~diff[XLEN+1];

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = div_by_zero ? ST_DONE : ST_CALC;
      ST_CALC: if (count_q == '0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // Divide-by-zero preloads the architectural result with both negate flags clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      remainder_q <= '0;
      quotient_q  <= '0;
      divisor_q   <= '0;
      count_q     <= '0;
      is_rem_q    <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else if (accept) begin
      is_rem_q <= op_rem;
      if (div_by_zero) begin
        quotient_q  <= '1;
        remainder_q <= {1'b0, operand_ra_i};
        divisor_q   <= '0;
        count_q     <= '0;
        neg_quo_q   <= 1'b0;
        neg_rem_q   <= 1'b0;
      end else begin
        quotient_q  <= magnitude(operand_ra_i, op_signed);
        remainder_q <= '0;
        divisor_q   <= magnitude(operand_rb_i, op_signed);
        count_q     <= CNT_W'(XLEN - 1);
        neg_quo_q   <= op_signed & (operand_ra_i[XLEN-1] ^ operand_rb_i[XLEN-1]);
        neg_rem_q   <= op_signed & operand_ra_i[XLEN-1];
      end
    end else if (state_q == ST_CALC) begin
      quotient_q  <= {quotient_q[XLEN-2:0], fits};
      remainder_q <= fits ? diff[XLEN:0] : {remainder_q[XLEN-1:0], quotient_q[XLEN-1]};
      count_q     <= count_q - 1'b1;
    end
  end

  always_comb begin
    if (is_rem_q) result = neg_rem_q ? -remainder_q[XLEN-1:0] : remainder_q[XLEN-1:0];
    else          result = neg_quo_q ? -quotient_q : quotient_q;
  end

  assign busy_o            = (state_q != ST_IDLE);
  assign writeback_valid_o = (state_q == ST_DONE) && !flush_i;
  assign writeback_value_o = (state_q == ST_DONE) ? result : '0;

endmodule

// File: tb/tb_biriscv_divider.sv
// Self-checking bench for biriscv_divider: scoreboard of expected results,
// latency/busy checks, divide-by-zero, overflow, flush and reset cases.
module tb_biriscv_divider;

  localparam int OP_DIV  = 0;
  localparam int OP_DIVU = 1;
  localparam int OP_REM  = 2;
  localparam int OP_REMU = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        opcode_valid = 1'b0;
  logic        inst_div = 1'b0;
  logic        inst_divu = 1'b0;
  logic        inst_rem = 1'b0;
  logic        inst_remu = 1'b0;
  logic [31:0] operand_ra = '0;
  logic [31:0] operand_rb = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        wb_valid;
  logic [31:0] wb_value;

  int          checks_total = 0;
  int          checks_passed = 0;
  logic [31:0] exp_q[$];

  biriscv_divider #(.XLEN(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .opcode_valid_i   (opcode_valid),
    .inst_div_i       (inst_div),
    .inst_divu_i      (inst_divu),
    .inst_rem_i       (inst_rem),
    .inst_remu_i      (inst_remu),
    .operand_ra_i     (operand_ra),
    .operand_rb_i     (operand_rb),
    .flush_i          (flush),
    .busy_o           (busy),
    .writeback_valid_o(wb_valid),
    .writeback_value_o(wb_value)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Architectural RV32M result, computed with native signed/unsigned arithmetic.
  function automatic logic [31:0] model_div(input int op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return (op == OP_DIV || op == OP_DIVU) ? 32'hFFFF_FFFF : a;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF && op == OP_DIV) return 32'h8000_0000;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF && op == OP_REM) return 32'h0;
    case (op)
      OP_DIV:  return sa / sb;
      OP_DIVU: return a / b;
      OP_REM:  return sa % sb;
      default: return a % b;
    endcase
  endfunction

  task automatic drive_request(input int op, input logic [31:0] ra, input logic [31:0] rb);
    opcode_valid = 1'b1;
    inst_div     = (op == OP_DIV);
    inst_divu    = (op == OP_DIVU);
    inst_rem     = (op == OP_REM);
    inst_remu    = (op == OP_REMU);
    operand_ra   = ra;
    operand_rb   = rb;
  endtask

  task automatic clear_request();
    opcode_valid = 1'b0;
    inst_div     = 1'b0;
    inst_divu    = 1'b0;
    inst_rem     = 1'b0;
    inst_remu    = 1'b0;
  endtask

  // Presents one request for its accept edge and returns in cycle 1.
  task automatic applyStimulus(input int op, input logic [31:0] ra, input logic [31:0] rb);
    drive_request(op, ra, rb);
    exp_q.push_back(model_div(op, ra, rb));
    @(posedge clk); #1;
    clear_request();
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int          n;
    logic [31:0] exp_val;
    n = 1;
    checkOutput({tag, " busy_c1"}, 32'(busy), 32'd1);
    while (!wb_valid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    exp_val = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    if (!wb_valid) begin
      checkOutput({tag, " timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({tag, " value"}, wb_value, exp_val);
      checkOutput({tag, " latency"}, 32'(n), 32'(exp_lat));
      checkOutput({tag, " busy_wb"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      checkOutput({tag, " busy_after"}, 32'(busy), 32'd0);
      checkOutput({tag, " one_pulse"}, 32'(wb_valid), 32'd0);
    end
  endtask

  initial begin
    logic stray;
    int   op;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset with a request held on the inputs.
    rst = 1'b1;
    drive_request(OP_DIVU, 32'd10, 32'd2);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset valid", 32'(wb_valid), 32'd0);
    checkOutput("reset value", wb_value, 32'd0);
    rst = 1'b0;
    clear_request();
    @(posedge clk); #1;
    checkOutput("reset req ignored", 32'(busy), 32'd0);

    applyStimulus(OP_DIVU, 32'd100, 32'd7);                  wait_result("divu 100/7", 33);
    applyStimulus(OP_REMU, 32'd100, 32'd7);                  wait_result("remu 100/7", 33);
    applyStimulus(OP_DIV, -32'sd7, 32'd2);                   wait_result("div -7/2", 33);
    applyStimulus(OP_REM, -32'sd7, 32'd2);                   wait_result("rem -7/2", 33);
    applyStimulus(OP_REM, 32'd7, -32'sd2);                   wait_result("rem 7/-2", 33);
    applyStimulus(OP_DIV, 32'd5, 32'd0);                     wait_result("div 5/0", 1);
    applyStimulus(OP_REMU, 32'h1234, 32'd0);                 wait_result("remu x/0", 1);
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);     wait_result("div ovf", 33);
    applyStimulus(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);     wait_result("rem ovf", 33);

    // Invalid request: valid with no instruction bit set.
    opcode_valid = 1'b1;
    operand_ra   = 32'd9;
    operand_rb   = 32'd3;
    @(posedge clk); #1;
    opcode_valid = 1'b0;
    checkOutput("no inst ignored", 32'(busy), 32'd0);

    // Flush coinciding with an accept wins.
    flush = 1'b1;
    drive_request(OP_DIV, 32'd9, 32'd3);
    @(posedge clk); #1;
    flush = 1'b0;
    clear_request();
    checkOutput("flush vs accept", 32'(busy), 32'd0);

    // Flush in cycle 10 of a DIVU, then a follow-up accepted in cycle 11.
    applyStimulus(OP_DIVU, 32'd1000, 32'd3);
    void'(exp_q.pop_front());
    stray = 1'b0;
    repeat (9) begin
      stray |= wb_valid;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    #0;
    stray |= wb_valid;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush no pulse", 32'(stray), 32'd0);
    checkOutput("flush busy c11", 32'(busy), 32'd0);
    applyStimulus(OP_DIVU, 32'd9, 32'd3);                    wait_result("divu 9/3 post flush", 33);

    // Reset in cycle 20 of an operation, with another request held during reset.
    applyStimulus(OP_DIV, -32'sd100, 32'd7);
    void'(exp_q.pop_front());
    repeat (19) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    drive_request(OP_REM, 32'd50, 32'd5);
    @(posedge clk); #1;
    checkOutput("midop reset busy", 32'(busy), 32'd0);
    checkOutput("midop reset valid", 32'(wb_valid), 32'd0);
    checkOutput("midop reset value", wb_value, 32'd0);
    rst = 1'b0;
    clear_request();
    stray = 1'b0;
    repeat (40) begin
      stray |= wb_valid | busy;
      @(posedge clk); #1;
    end
    checkOutput("midop reset quiet", 32'(stray), 32'd0);

    // Randomised mix, including occasional small and zero divisors.
    for (int i = 0; i < 10; i++) begin
      op = int'($urandom_range(0, 3));
      ra = $urandom();
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = -32'($urandom_range(1, 1000));
        default: rb = $urandom();
      endcase
      applyStimulus(op, ra, rb);
      wait_result($sformatf("rand%0d op%0d", i, op), (rb == 32'd0) ? 1 : 33);
    end

    checkOutput("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
